// File: rtl/elastic_pipe.sv
// W-bit, L-stage elastic delay line with per-stage valid/ready, bubble collapse, flush and occupancy.
// Build option: define ELASTIC_PIPE_SKID_EN for a registered-ready skid entry in front of stage 0.
module elastic_pipe #(
  parameter int W = 8,
  parameter int L = 2,
  localparam int OW = $clog2(L+2)
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [W-1:0]  IN_DATA,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [W-1:0]  OUT_DATA,
  input  logic          FLUSH,
  output logic [OW-1:0] OCC
);

  logic [L-1:0]  v_q, v_d;
  logic [L-1:0]  en;
  logic [L-1:0]  up_v;
  logic [W-1:0]  d_q  [L];
  logic [W-1:0]  d_d  [L];
  logic [W-1:0]  up_d [L];
  logic          src_v;
  logic [W-1:0]  src_d;
  logic          skid_v_d;
  logic [OW-1:0] occ_q, occ_d;

`ifdef ELASTIC_PIPE_SKID_EN
  logic          sv_q, sv_d;
  logic [W-1:0]  sd_q, sd_d;

  // IN_READY comes only from the skid flag, breaking the OUT_READY-to-IN_READY path.
  assign IN_READY = !sv_q && !FLUSH;
  assign src_v    = sv_q || IN_VALID;
  assign src_d    = sv_q ? sd_q : IN_DATA;
  assign skid_v_d = sv_d;

  always_comb begin
    sv_d = sv_q;
    sd_d = sd_q;
    if (FLUSH) begin
      sv_d = 1'b0;
    end else if (en[0]) begin
      sv_d = 1'b0;
    end else if (IN_VALID && IN_READY) begin
      sv_d = 1'b1;
      sd_d = IN_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sv_q <= 1'b0;
      sd_q <= '0;
    end else begin
      sv_q <= sv_d;
      sd_q <= sd_d;
    end
  end
`else
  assign IN_READY = en[0] && !FLUSH;
  assign src_v    = IN_VALID;
  assign src_d    = IN_DATA;
  assign skid_v_d = 1'b0;
`endif

  // A stage may load whenever it is empty or everything downstream moves.
  always_comb begin
    en = '0;
    en[L-1] = !v_q[L-1] || OUT_READY;
    for (int i = L-2; i >= 0; i--) begin
      en[i] = !v_q[i] || en[i+1];
    end
  end

  always_comb begin
    up_v    = '0;
    up_v[0] = src_v;
    up_d[0] = src_d;
    for (int i = 1; i < L; i++) begin
      up_v[i] = v_q[i-1];
      up_d[i] = d_q[i-1];
    end
  end

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < L; i++) begin
      d_d[i] = d_q[i];
      if (FLUSH) begin
        v_d[i] = 1'b0;
      end else if (en[i]) begin
        v_d[i] = up_v[i];
        if (up_v[i]) d_d[i] = up_d[i];
      end
    end
  end

  always_comb begin
    occ_d = OW'(skid_v_d);
    for (int i = 0; i < L; i++) begin
      occ_d = occ_d + OW'(v_d[i]);
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < L; i++) d_q[i] <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int i = 0; i < L; i++) d_q[i] <= d_d[i];
    end
  end

  assign OUT_VALID = v_q[L-1];
  assign OUT_DATA  = d_q[L-1];
  assign OCC       = occ_q;

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed and randomized checks for elastic_pipe with W=8, L=3.
module tb_elastic_pipe;

  localparam int W  = 8;
  localparam int L  = 3;
  localparam int OW = $clog2(L+2);
`ifdef ELASTIC_PIPE_SKID_EN
  localparam int CAP = L + 1;
`else
  localparam int CAP = L;
`endif

  logic          CLK;
  logic          RSTN;
  logic          IN_VALID;
  logic          IN_READY;
  logic [W-1:0]  IN_DATA;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [W-1:0]  OUT_DATA;
  logic          FLUSH;
  logic [OW-1:0] OCC;

  int n_cmp = 0;
  int n_err = 0;

  elastic_pipe #(.W(W), .L(L)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .FLUSH(FLUSH), .OCC(OCC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    IN_VALID = 1'b0; OUT_READY = 1'b0; FLUSH = 1'b0; IN_DATA = '0;
    RSTN = 1'b0;
    cyc(); cyc();
    RSTN = 1'b1;
  endtask

  task automatic test_reset();
    IN_VALID = 1'b0; OUT_READY = 1'b0; FLUSH = 1'b0; IN_DATA = 8'h5A;
    RSTN = 1'b0;
    #2;
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", OUT_VALID); end
    n_cmp++; if (OUT_DATA !== 8'h00) begin n_err++; $display("FAIL reset_out_data got=%h want=00", OUT_DATA); end
    n_cmp++; if (OCC !== 3'd0) begin n_err++; $display("FAIL reset_occ got=%0d want=0", OCC); end
    cyc();
    RSTN = 1'b1;
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b want=1", IN_READY); end
  endtask

  task automatic test_stream();
    int  acc, dlv, exp_occ;
    logic exp_v;
    do_reset();
    OUT_READY = 1'b1;
    for (int e = 1; e <= 16 + L + 1; e++) begin
      IN_VALID = (e <= 16);
      IN_DATA  = 8'(e);
      #1;
      if (e <= 16) begin
        n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL stream_in_ready e=%0d got=%b want=1", e, IN_READY); end
      end
      cyc();
      exp_v = (e >= L) && (e <= 15 + L);
      n_cmp++; if (OUT_VALID !== exp_v) begin n_err++; $display("FAIL stream_out_valid e=%0d got=%b want=%b", e, OUT_VALID, exp_v); end
      if (exp_v) begin
        n_cmp++; if (OUT_DATA !== 8'(e - L + 1)) begin n_err++; $display("FAIL stream_out_data e=%0d got=%h want=%h", e, OUT_DATA, 8'(e - L + 1)); end
      end
      acc = (e < 16) ? e : 16;
      dlv = (e - L < 0) ? 0 : ((e - L > 16) ? 16 : e - L);
      exp_occ = acc - dlv;
      n_cmp++; if (int'(OCC) != exp_occ) begin n_err++; $display("FAIL stream_occ e=%0d got=%0d want=%0d", e, OCC, exp_occ); end
    end
    IN_VALID = 1'b0;
  endtask

  task automatic test_stall();
    int   acc, got;
    logic exp_rdy;
    do_reset();
    acc = 0;
    OUT_READY = 1'b0;
    for (int c = 0; c < 6; c++) begin
      IN_VALID = 1'b1;
      IN_DATA  = 8'(8'hA0 + acc);
      #1;
      exp_rdy = (c < CAP);
      n_cmp++; if (IN_READY !== exp_rdy) begin n_err++; $display("FAIL stall_in_ready c=%0d got=%b want=%b", c, IN_READY, exp_rdy); end
      if (IN_READY) acc++;
      cyc();
    end
    n_cmp++; if (int'(OCC) != CAP) begin n_err++; $display("FAIL stall_occ got=%0d want=%0d", OCC, CAP); end
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (OUT_VALID) begin
        n_cmp++; if (OUT_DATA !== 8'(8'hA0 + got)) begin n_err++; $display("FAIL stall_drain_data n=%0d got=%h want=%h", got, OUT_DATA, 8'(8'hA0 + got)); end
        got++;
      end
      cyc();
    end
    n_cmp++; if (got != CAP) begin n_err++; $display("FAIL stall_drain_count got=%0d want=%0d", got, CAP); end
    n_cmp++; if (OCC !== 3'd0) begin n_err++; $display("FAIL stall_drain_occ got=%0d want=0", OCC); end
  endtask

  task automatic test_bubble();
    do_reset();
    OUT_READY = 1'b0;
    IN_VALID = 1'b1; IN_DATA = 8'h11; cyc();
    IN_VALID = 1'b0;                  cyc();
    IN_VALID = 1'b1; IN_DATA = 8'h22; cyc();
    IN_VALID = 1'b0;                  cyc();
    n_cmp++; if (OCC !== 3'd2) begin n_err++; $display("FAIL bubble_occ got=%0d want=2", OCC); end
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h11) begin n_err++; $display("FAIL bubble_head got=%b/%h want=1/11", OUT_VALID, OUT_DATA); end
    // 0x22 must be in the stage right behind the head: it shows up the very next cycle.
    OUT_READY = 1'b1;
    cyc();
    n_cmp++; if (OUT_VALID !== 1'b1 || OUT_DATA !== 8'h22) begin n_err++; $display("FAIL bubble_second got=%b/%h want=1/22", OUT_VALID, OUT_DATA); end
    cyc();
    n_cmp++; if (OUT_VALID !== 1'b0 || OCC !== 3'd0) begin n_err++; $display("FAIL bubble_empty got=%b/%0d want=0/0", OUT_VALID, OCC); end
  endtask

  task automatic test_flush();
    do_reset();
    OUT_READY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      IN_VALID = 1'b1; IN_DATA = 8'(8'h31 + k); cyc();
    end
    n_cmp++; if (OCC !== 3'd3) begin n_err++; $display("FAIL flush_fill_occ got=%0d want=3", OCC); end
    FLUSH = 1'b1; IN_VALID = 1'b1; IN_DATA = 8'h44;
    #1;
    n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got=%b want=0", IN_READY); end
    n_cmp++; if (OUT_VALID !== 1'b1) begin n_err++; $display("FAIL flush_out_valid_during got=%b want=1", OUT_VALID); end
    cyc();
    FLUSH = 1'b0; IN_VALID = 1'b0;
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL flush_out_valid_after got=%b want=0", OUT_VALID); end
    n_cmp++; if (OCC !== 3'd0) begin n_err++; $display("FAIL flush_occ_after got=%0d want=0", OCC); end
    IN_VALID = 1'b1; IN_DATA = 8'h55; OUT_READY = 1'b1;
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL flush_ready_after got=%b want=1", IN_READY); end
    cyc();
    IN_VALID = 1'b0;
    for (int e = 1; e <= L; e++) begin
      if (e > 1) cyc();
      n_cmp++; if (OUT_VALID !== (e == L)) begin n_err++; $display("FAIL flush_relatency e=%0d got=%b want=%b", e, OUT_VALID, (e == L)); end
    end
    n_cmp++; if (OUT_DATA !== 8'h55) begin n_err++; $display("FAIL flush_reword got=%h want=55", OUT_DATA); end
  endtask

  task automatic test_async_reset();
    do_reset();
    OUT_READY = 1'b1;
    for (int k = 0; k < 5; k++) begin
      IN_VALID = 1'b1; IN_DATA = 8'(8'h61 + k); cyc();
    end
    #2;
    RSTN = 1'b0;
    #1;
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL arst_out_valid got=%b want=0", OUT_VALID); end
    n_cmp++; if (OUT_DATA !== 8'h00) begin n_err++; $display("FAIL arst_out_data got=%h want=00", OUT_DATA); end
    n_cmp++; if (OCC !== 3'd0) begin n_err++; $display("FAIL arst_occ got=%0d want=0", OCC); end
    cyc();
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL arst_hold_valid got=%b want=0", OUT_VALID); end
    IN_VALID = 1'b0;
    RSTN = 1'b1;
    #1;
    n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL arst_in_ready got=%b want=1", IN_READY); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] nxt;
    logic       acc, dlv;
    do_reset();
    nxt = 8'h00;
    for (int n = 0; n < 10000; n++) begin
      IN_VALID  = 1'($urandom_range(0, 1));
      OUT_READY = 1'($urandom_range(0, 1));
      IN_DATA   = nxt;
      #1;
      acc = IN_VALID && IN_READY;
      dlv = OUT_VALID && OUT_READY;
      if (dlv) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL rand_spurious n=%0d got=%h want=none", n, OUT_DATA);
        end else begin
          if (OUT_DATA !== q[0]) begin n_err++; $display("FAIL rand_order n=%0d got=%h want=%h", n, OUT_DATA, q[0]); end
          void'(q.pop_front());
        end
      end
      if (acc) begin
        q.push_back(nxt);
        nxt = nxt + 8'd1;
      end
      cyc();
      n_cmp++; if (int'(OCC) != q.size()) begin n_err++; $display("FAIL rand_occ n=%0d got=%0d want=%0d", n, OCC, q.size()); end
      n_cmp++; if (int'(OCC) > CAP) begin n_err++; $display("FAIL rand_cap n=%0d got=%0d want<=%0d", n, OCC, CAP); end
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b0;
  endtask

  initial begin
    RSTN = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0; FLUSH = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_bubble();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
